// File: rtl/simon_datapath.sv
// Simon game datapath: pattern memory, stored-length and replay counters,
// and player-input validation against the difficulty latched at reset.
module simon_datapath #(
    parameter int PATTERN_W = 4,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 level,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic                 scld,
    input  logic                 srld,
    input  logic                 rcld,
    input  logic                 rcclr,
    input  logic                 led_sel,
    output logic                 is_legal,
    output logic                 correct_pattern,
    output logic                 is_last_element,
    output logic [PATTERN_W-1:0] pattern_leds,
    output logic [ADDR_W:0]      seq_len
);

    localparam logic [ADDR_W:0]   COUNT_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] REPLAY_MAX = ADDR_W'(DEPTH-1);

    logic [PATTERN_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]      count_q, count_d;
    logic [ADDR_W-1:0]    replay_q, replay_d;
    logic                 level_q;
    logic                 mem_we;
    logic                 rd_valid;
    logic [PATTERN_W-1:0] rd_data;

    always_comb begin
        count_d  = count_q;
        replay_d = replay_q;
        if (scld && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
        if (rcclr) begin
            replay_d = '0;
        end else if (rcld && (replay_q != REPLAY_MAX)) begin
            replay_d = replay_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            replay_q <= '0;
            level_q  <= level;
        end else begin
            count_q  <= count_d;
            replay_q <= replay_d;
        end
    end

    // Write uses the pre-edge count, so srld+scld together append one element.
    assign mem_we = !rst && srld && (count_q < COUNT_MAX);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[count_q[ADDR_W-1:0]] <= pattern;
        end
    end

    assign rd_valid = ({1'b0, replay_q} < count_q);
    assign rd_data  = rd_valid ? mem_q[replay_q] : '0;

    assign is_legal        = level_q | $onehot(pattern);
    assign correct_pattern = rd_valid && (pattern == rd_data);
    assign is_last_element = (count_q != '0) && ({1'b0, replay_q} == (count_q - 1'b1));
    assign pattern_leds    = led_sel ? pattern : rd_data;
    assign seq_len         = count_q;

endmodule

// File: tb/tb_simon_datapath.sv
// Directed bench for simon_datapath; expectations go through a scoreboard
// queue and are checked with immediate assertions.
`timescale 1ns/1ps
module tb_simon_datapath;

    logic       clk = 1'b0;
    logic       rst, level, scld, srld, rcld, rcclr, led_sel;
    logic [3:0] pattern;
    logic       is_legal, correct_pattern, is_last_element;
    logic [3:0] pattern_leds;
    logic [6:0] seq_len;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;
    exp_t sb[$];

    // reference state
    logic [3:0] m_mem [64];
    int         m_count, m_replay;
    logic       m_level;

    simon_datapath #(.PATTERN_W(4), .DEPTH(64), .ADDR_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .level           (level),
        .pattern         (pattern),
        .scld            (scld),
        .srld            (srld),
        .rcld            (rcld),
        .rcclr           (rcclr),
        .led_sel         (led_sel),
        .is_legal        (is_legal),
        .correct_pattern (correct_pattern),
        .is_last_element (is_last_element),
        .pattern_leds    (pattern_leds),
        .seq_len         (seq_len)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs(int sel);
        case (sel)
            0:       return {7'd0, is_legal};
            1:       return {7'd0, correct_pattern};
            2:       return {7'd0, is_last_element};
            3:       return {4'd0, pattern_leds};
            default: return {1'b0, seq_len};
        endcase
    endfunction

    function automatic string sel_name(int sel);
        case (sel)
            0:       return "is_legal";
            1:       return "correct_pattern";
            2:       return "is_last_element";
            3:       return "pattern_leds";
            default: return "seq_len";
        endcase
    endfunction

    task automatic push(string tag, int sel, logic [7:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic push_model(string tag);
        logic       v;
        logic [3:0] rd;
        v  = (m_replay < m_count);
        rd = v ? m_mem[m_replay] : 4'h0;
        push(tag, 0, {7'd0, m_level | $onehot(pattern)});
        push(tag, 1, {7'd0, v && (pattern == rd)});
        push(tag, 2, {7'd0, (m_count != 0) && (m_replay == m_count - 1)});
        push(tag, 3, {4'd0, led_sel ? pattern : rd});
        push(tag, 4, 8'(m_count));
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] o;
        #0.5;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            n_cmp++;
            assert (o === e.exp)
            else begin
                n_err++;
                $error("FAIL %s.%s observed=%0h expected=%0h", e.tag, sel_name(e.sel), o, e.exp);
            end
        end
    endtask

    task automatic check(string tag);
        push_model(tag);
        drain();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_count  = 0;
            m_replay = 0;
            m_level  = level;
        end else begin
            if (srld && m_count < 64) m_mem[m_count] = pattern;
            if (scld && m_count < 64) m_count++;
            if (rcclr) m_replay = 0;
            else if (rcld && m_replay < 63) m_replay++;
        end
        #1;
    endtask

    task automatic strobes(logic sc, logic sr, logic rc, logic cl);
        scld  = sc;
        srld  = sr;
        rcld  = rc;
        rcclr = cl;
    endtask

    initial begin
        rst = 1'b1; level = 1'b0; pattern = 4'h0; led_sel = 1'b0;
        strobes(0, 0, 0, 0);
        m_count = 0; m_replay = 0; m_level = 1'b0;

        // easy level
        tick();
        rst = 1'b0;
        pattern = 4'b0110;
        push("easy_0110", 0, 8'd0); push("easy_0110", 4, 8'd0);
        push("easy_0110", 2, 8'd0); push("easy_0110", 1, 8'd0);
        push("easy_0110", 3, 8'd0);
        check("easy_0110");
        pattern = 4'b0100;
        push("easy_0100", 0, 8'd1);
        check("easy_0100");
        pattern = 4'b0000;
        push("easy_zero", 0, 8'd0);
        check("easy_zero");
        pattern = 4'b1000;
        check("easy_1000");
        level = 1'b1;
        tick();
        pattern = 4'b0011;
        push("level_ignored", 0, 8'd0);
        check("level_ignored");

        // hard level latched at reset
        rst = 1'b1; level = 1'b1;
        tick();
        rst = 1'b0; level = 1'b0; pattern = 4'b1111;
        push("hard_1111", 0, 8'd1);
        check("hard_1111");
        tick();
        push("hard_latched", 0, 8'd1);
        check("hard_latched");

        // store 1,2,8
        strobes(1, 1, 0, 0);
        pattern = 4'h1; tick(); check("store0");
        pattern = 4'h2; tick(); check("store1");
        pattern = 4'h8; tick();
        strobes(0, 0, 0, 0);
        push("store_len", 4, 8'd3);
        check("store_len");

        strobes(0, 0, 0, 1); tick(); strobes(0, 0, 0, 0);
        led_sel = 1'b0;
        push("replay0", 3, 8'h1);
        check("replay0");
        strobes(0, 0, 1, 0); tick(); strobes(0, 0, 0, 0);
        push("replay1", 3, 8'h2);
        check("replay1");
        strobes(0, 0, 1, 0); tick(); strobes(0, 0, 0, 0);
        push("replay2", 3, 8'h8); push("replay2", 2, 8'd1);
        check("replay2");
        led_sel = 1'b1; pattern = 4'h6;
        push("led_sel", 3, 8'h6);
        check("led_sel");
        led_sel = 1'b0;

        // repeat check
        strobes(0, 0, 0, 1); tick(); strobes(0, 0, 0, 0);
        pattern = 4'h1;
        push("rep_ok0", 1, 8'd1);
        check("rep_ok0");
        pattern = 4'h4;
        push("rep_bad0", 1, 8'd0);
        check("rep_bad0");
        strobes(0, 0, 1, 0); tick(); strobes(0, 0, 0, 0);
        pattern = 4'h2;
        push("rep_ok1", 1, 8'd1); push("rep_ok1", 2, 8'd0);
        check("rep_ok1");

        // reset mid-sequence at replay=2
        strobes(0, 0, 1, 0); tick(); strobes(0, 0, 0, 0);
        pattern = 4'h8;
        check("pre_rst");
        rst = 1'b1; level = 1'b1; tick(); rst = 1'b0;
        pattern = 4'h1;
        push("mid_rst", 4, 8'd0); push("mid_rst", 1, 8'd0);
        push("mid_rst", 3, 8'd0); push("mid_rst", 2, 8'd0);
        check("mid_rst");

        // srld alone writes without growing; scld alone exposes it
        pattern = 4'h9;
        strobes(0, 1, 0, 0); tick(); strobes(0, 0, 0, 0);
        push("srld_only", 4, 8'd0); push("srld_only", 3, 8'd0);
        check("srld_only");
        strobes(1, 0, 0, 0); tick(); strobes(0, 0, 0, 0);
        push("scld_only", 4, 8'd1); push("scld_only", 3, 8'h9);
        push("scld_only", 1, 8'd1); push("scld_only", 2, 8'd1);
        check("scld_only");

        // fill to DEPTH
        rst = 1'b1; tick(); rst = 1'b0;
        strobes(1, 1, 0, 0);
        for (int i = 0; i < 64; i++) begin
            pattern = 4'(i) ^ 4'hA;
            tick();
            if (i % 8 == 7) check("fill");
        end
        push("full_len", 4, 8'd64);
        check("full_len");
        pattern = 4'hF;
        tick();
        strobes(0, 0, 0, 0);
        push("over_len", 4, 8'd64);
        check("over_len");

        strobes(0, 0, 0, 1); tick();
        strobes(0, 0, 1, 0);
        for (int i = 0; i < 70; i++) begin
            tick();
            if (i % 10 == 9) check("rcld_run");
        end
        strobes(0, 0, 0, 0);
        pattern = 4'h5;
        push("sat_last", 3, 8'h5); push("sat_last", 2, 8'd1);
        push("sat_last", 1, 8'd1);
        check("sat_last");
        strobes(0, 0, 1, 1); tick(); strobes(0, 0, 0, 0);
        push("clr_prio", 3, 8'hA); push("clr_prio", 2, 8'd0);
        check("clr_prio");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
